// File: rtl/ha_array_pkg.sv
// ha_array_pkg: shared widths, FSM state and row type for the half-adder array accumulator
package ha_array_pkg;
  localparam int ROW_T_W = 9;
  localparam int ROW_B_W = 7;
  localparam int PROD_W = 16;
  localparam int ACC_W = 17;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  typedef struct packed {
    logic [ROW_B_W-1:0] b;
    logic [ROW_T_W-1:0] t;
  } row_t;
endpackage

// File: rtl/ha_row_weight.sv
// ha_row_weight: weights one ha_array row (t + b<<2) by its row shift 2k into a 17-bit contribution
// Ports: row {b,t} in, k row index in, contribution out.
module ha_row_weight
  import ha_array_pkg::*;
(
  input  row_t             row,
  input  logic [1:0]       k,
  output logic [ACC_W-1:0] contribution
);
  assign contribution = (ACC_W'(row.t) + (ACC_W'(row.b) << 2)) << {k, 1'b0};
endmodule

// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator: sequentially sums four ha_array rows into a saturated 16-bit product
// Ports: clk, rst (async high); in_valid/in_ready + ha_array_{0..3}_{b,t} row inputs;
// out_valid/out_ready + product/ovf result. Macro HA_ARRAY_ACC_COMP_EN adds COMP_BIAS before saturation.
module ha_array_accumulator
  import ha_array_pkg::*;
#(
  parameter int ROWS = 4,
  parameter logic [PROD_W-1:0] COMP_BIAS = 16'd365
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROW_B_W-1:0] ha_array_0_b,
  input  logic [ROW_B_W-1:0] ha_array_1_b,
  input  logic [ROW_B_W-1:0] ha_array_2_b,
  input  logic [ROW_B_W-1:0] ha_array_3_b,
  input  logic [ROW_T_W-1:0] ha_array_0_t,
  input  logic [ROW_T_W-1:0] ha_array_1_t,
  input  logic [ROW_T_W-1:0] ha_array_2_t,
  input  logic [ROW_T_W-1:0] ha_array_3_t,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PROD_W-1:0]  product,
  output logic               ovf
);
  localparam int CW = $clog2(ROWS + 1);
`ifdef HA_ARRAY_ACC_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif
  localparam logic [PROD_W-1:0] BIAS = COMP ? COMP_BIAS : '0;
  state_t state;
  row_t rows [4];
  logic [ACC_W-1:0] acc, contribution, sum;
  logic [CW-1:0] cnt;
  ha_row_weight u_weight (
    .row(rows[cnt[1:0]]),
    .k(cnt[1:0]),
    .contribution(contribution)
  );
  // The extra ACC cycle at cnt==ROWS finalises the result: bias and saturation happen on the DONE entry edge.
  assign sum = acc + ACC_W'(BIAS);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      product <= '0;
      ovf <= 1'b0;
      acc <= '0;
      cnt <= '0;
      rows <= '{default: '0};
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            rows <= '{row_t'{ha_array_0_b, ha_array_0_t}, row_t'{ha_array_1_b, ha_array_1_t},
                      row_t'{ha_array_2_b, ha_array_2_t}, row_t'{ha_array_3_b, ha_array_3_t}};
            acc <= '0;
            cnt <= '0;
            in_ready <= 1'b0;
            state <= ACC;
          end
        ACC:
          if (cnt == CW'(ROWS)) begin
            product <= sum[ACC_W-1] ? '1 : sum[PROD_W-1:0];
            ovf <= sum[ACC_W-1];
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            acc <= acc + contribution;
            cnt <= cnt + CW'(1);
          end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ha_array_accumulator.sv
// tb_ha_array_accumulator: directed and random checks of ha_array_accumulator against an arithmetic model
module tb_ha_array_accumulator;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [15:0] product;
  logic [6:0] b [4];
  logic [8:0] t [4];
  int checks = 0, errors = 0;
`ifdef HA_ARRAY_ACC_COMP_EN
  localparam int BIAS = 365;
`else
  localparam int BIAS = 0;
`endif
  always #5 clk = ~clk;
  ha_array_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b[0]), .ha_array_1_b(b[1]), .ha_array_2_b(b[2]), .ha_array_3_b(b[3]),
    .ha_array_0_t(t[0]), .ha_array_1_t(t[1]), .ha_array_2_t(t[2]), .ha_array_3_t(t[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear();
    for (int k = 0; k < 4; k++) begin
      b[k] = '0;
      t[k] = '0;
    end
  endtask
  task automatic scramble();
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'($urandom);
      t[k] = 9'($urandom);
    end
  endtask
  // Runs one transaction on the current rows, holding out_ready low for hold cycles in DONE.
  task automatic op(input string tag, input int hold);
    int s, n;
    logic [15:0] ep;
    logic [15:0] held;
    s = BIAS;
    for (int k = 0; k < 4; k++) s += (int'(t[k]) + 4 * int'(b[k])) * (1 << (2 * k));
    ep = s > 65535 ? 16'hFFFF : s[15:0];
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid) chk({tag, "_in_ready_busy"}, in_ready, 0);
    end while (!out_valid && n < 20);
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_product"}, product, ep);
    chk({tag, "_ovf"}, ovf, s > 65535);
    held = product;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_product"}, product, held);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_in_ready"}, in_ready, 1);
  endtask
  initial begin
    clear();
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_product", product, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    clear();
    op("zero", 0);
    clear(); t[0] = 9'h001;
    op("t0_lsb", 0);
    clear(); t[3] = 9'h001;
    op("t3_lsb", 1);
    clear(); b[3] = 7'h40;
    op("b3_msb", 0);
    clear(); t[0] = 9'h1FF;
    op("t0_full", 0);
    for (int k = 0; k < 4; k++) begin
      b[k] = 7'h7F;
      t[k] = 9'h1FF;
    end
    op("all_ones", 0);
    scramble();
    op("backpressure", 10);
    clear();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("rst_no_output", out_valid, 0);
    end
    clear(); t[1] = 9'h003;
    op("after_rst", 0);
    for (int i = 0; i < 12; i++) begin
      scramble();
      if (i % 3 == 0) begin
        b[3] = 7'h7F;
        t[3] = 9'h1FF;
      end
      op("random", int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
